serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 138 +++++++++++++
 tb/tb_serial_addsub.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// serial_addsub -- bit-serial adder/subtractor.
//
// A single full adder processes one operand bit per clock, LSB first. An
// operation takes WIDTH cycles after acceptance. Subtraction is computed as
// a + ~b + 1, with the +1 entering as the initial carry.
//
// Parameters:
//   WIDTH          operand width in bits, legal range 2..32
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   start          operation request, accepted only when idle
//   sub            0 = a+b, 1 = a-b, sampled with start
//   a, b           operands, sampled with start
//   busy           high while an operation is in progress
//   done           one-cycle pulse, result registers just updated
//   sum            result register, held between completions
//   cout           carry out of the MSB (not-borrow when subtracting)
//   ovf            two's-complement overflow
//   sum_bit        serial result bit, LSB first, 0 when not valid
//   sum_bit_valid  qualifier for sum_bit, high only while shifting
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             sum_bit,
    output logic             sum_bit_valid
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;   // result under construction, kept apart from sum
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;

    // Full adder on the current LSBs.
    always_comb begin
        fa_sum   = a_sr[0] ^ b_sr[0] ^ carry;
        fa_carry = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers sample the values from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the default assignment first guarantees state_next is driven on
    // every path, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // busy and the serial stream follow the state directly, so they are
    // low in IDLE without needing their own registers.
    assign busy          = (state == SHIFT);
    assign sum_bit_valid = (state == SHIFT);
    assign sum_bit       = (state == SHIFT) & fa_sum;

    // NOTE: every register here, shift registers included, takes the reset so
    // an aborted operation leaves no stale operand, carry or result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_carry;
                    res_sr <= {fa_sum, res_sr[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= {fa_sum, res_sr[WIDTH-1:1]};
                        cout <= fa_carry;
                        // carry still holds the carry into the MSB here.
                        ovf  <= carry ^ fa_carry;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: three instances (WIDTH 8, 2, 32) sharing
// reset, mode and operand buses, each with its own start. Results are compared
// against an arithmetic reference model.
module tb_serial_addsub;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sub_in;
    logic        start8, start2, start32;
    logic [31:0] a_in, b_in;

    logic        busy8, done8, cout8, ovf8, sb8, sbv8;
    logic [7:0]  sum8;
    logic        busy2, done2, cout2, ovf2, sb2, sbv2;
    logic [1:0]  sum2;
    logic        busy32, done32, cout32, ovf32, sb32, sbv32;
    logic [31:0] sum32;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_sum [0:32];

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub_in),
        .a(a_in[7:0]), .b(b_in[7:0]), .busy(busy8), .done(done8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .sum_bit(sb8), .sum_bit_valid(sbv8)
    );

    serial_addsub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub_in),
        .a(a_in[1:0]), .b(b_in[1:0]), .busy(busy2), .done(done2),
        .sum(sum2), .cout(cout2), .ovf(ovf2), .sum_bit(sb2), .sum_bit_valid(sbv2)
    );

    serial_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(sub_in),
        .a(a_in), .b(b_in), .busy(busy32), .done(done32),
        .sum(sum32), .cout(cout32), .ovf(ovf32), .sum_bit(sb32), .sum_bit_valid(sbv32)
    );

    typedef struct {
        logic        busy;
        logic        done;
        logic        cout;
        logic        ovf;
        logic        sb;
        logic        sbv;
        logic [31:0] sum;
    } obs_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    // Reference: plain modular arithmetic, unsigned compare for the carry,
    // signed range check for overflow.
    function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        res_t              r;
        longint unsigned   mask, av, bv, raw;
        longint            sa, sbs, sres, lim;
        mask = (64'd1 << w) - 64'd1;
        av   = 64'(a) & mask;
        bv   = 64'(b) & mask;
        if (s) begin
            raw    = (av - bv) & mask;
            r.cout = (av >= bv);
        end else begin
            raw    = av + bv;
            r.cout = raw[w];
            raw    = raw & mask;
        end
        r.sum = raw[31:0];
        sa  = longint'(av);
        sbs = longint'(bv);
        if (av[w-1]) sa  = sa  - (longint'(1) << w);
        if (bv[w-1]) sbs = sbs - (longint'(1) << w);
        sres  = s ? (sa - sbs) : (sa + sbs);
        lim   = longint'(1) << (w - 1);
        r.ovf = (sres >= lim) || (sres < -lim);
        return r;
    endfunction

    function automatic obs_t observe(input int w);
        obs_t o;
        case (w)
            2: begin
                o.busy = busy2; o.done = done2; o.cout = cout2; o.ovf = ovf2;
                o.sb = sb2; o.sbv = sbv2; o.sum = {30'b0, sum2};
            end
            8: begin
                o.busy = busy8; o.done = done8; o.cout = cout8; o.ovf = ovf8;
                o.sb = sb8; o.sbv = sbv8; o.sum = {24'b0, sum8};
            end
            default: begin
                o.busy = busy32; o.done = done32; o.cout = cout32; o.ovf = ovf32;
                o.sb = sb32; o.sbv = sbv32; o.sum = sum32;
            end
        endcase
        return o;
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            2:       start2  = v;
            8:       start8  = v;
            default: start32 = v;
        endcase
    endtask

    // Presents an operation and returns just after the accepting edge with
    // start already dropped.
    task automatic start_op(input int w, input logic [31:0] a, input logic [31:0] b,
                            input logic s);
        @(negedge clk);
        a_in   = a;
        b_in   = b;
        sub_in = s;
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
    endtask

    // Called just after the accepting edge. Follows the operation to done.
    // mode 0: inputs left alone; 1: operands/mode scrambled each cycle;
    // 2: as 1 plus start pulses at cycles 3 and 5.
    task automatic track(input int w, input logic [31:0] es, input logic ec, input logic eo,
                         input int mode, input string name);
        obs_t        o;
        int          k;
        bit          seen;
        logic [31:0] stream;
        stream = '0;
        seen   = 1'b0;
        k      = 0;
        for (int i = 1; i <= w + 4 && !seen; i++) begin
            @(negedge clk);
            o = observe(w);
            if (o.done) begin
                seen = 1'b1;
                k    = i;
            end else begin
                checks++;
                if (o.busy !== 1'b1 || o.sbv !== 1'b1) begin
                    failures++;
                    $display("FAIL %s w=%0d busy/valid cycle %0d: got busy=%b valid=%b, want 1/1",
                             name, w, i, o.busy, o.sbv);
                end
                if (i <= w) stream[i-1] = o.sb;
                checks++;
                if (o.sum !== last_sum[w]) begin
                    failures++;
                    $display("FAIL %s w=%0d sum_hold cycle %0d: got %h, want %h",
                             name, w, i, o.sum, last_sum[w]);
                end
                if (mode >= 1) begin
                    a_in   = $urandom;
                    b_in   = $urandom;
                    sub_in = 1'($urandom);
                end
                if (mode == 2) begin
                    if (i == 3 || i == 5) set_start(w, 1'b1);
                    if (i == 4 || i == 6) set_start(w, 1'b0);
                end
            end
        end
        if (mode == 2) set_start(w, 1'b0);
        checks++;
        if (k != w + 1) begin
            failures++;
            $display("FAIL %s w=%0d latency: done at cycle %0d, want %0d", name, w, k, w + 1);
        end
        if (seen) begin
            checks++;
            if (o.busy !== 1'b0 || o.sbv !== 1'b0 || o.sb !== 1'b0) begin
                failures++;
                $display("FAIL %s w=%0d done_cycle: got busy=%b valid=%b bit=%b, want 0/0/0",
                         name, w, o.busy, o.sbv, o.sb);
            end
            checks++;
            if (o.sum !== es) begin
                failures++;
                $display("FAIL %s w=%0d sum: got %h, want %h", name, w, o.sum, es);
            end
            checks++;
            if (o.cout !== ec) begin
                failures++;
                $display("FAIL %s w=%0d cout: got %b, want %b", name, w, o.cout, ec);
            end
            checks++;
            if (o.ovf !== eo) begin
                failures++;
                $display("FAIL %s w=%0d ovf: got %b, want %b", name, w, o.ovf, eo);
            end
            checks++;
            if (stream !== es) begin
                failures++;
                $display("FAIL %s w=%0d stream: got %h, want %h", name, w, stream, es);
            end
        end
        last_sum[w] = es;
    endtask

    task automatic check_idle_zero(input int w, input string name);
        obs_t o;
        o = observe(w);
        checks++;
        if (o.busy !== 1'b0 || o.done !== 1'b0 || o.sum !== 32'h0 || o.cout !== 1'b0 ||
            o.ovf !== 1'b0 || o.sb !== 1'b0 || o.sbv !== 1'b0) begin
            failures++;
            $display("FAIL %s w=%0d: got busy=%b done=%b sum=%h cout=%b ovf=%b bit=%b valid=%b, want all 0",
                     name, w, o.busy, o.done, o.sum, o.cout, o.ovf, o.sb, o.sbv);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        sub_in  = 1'b0;
        a_in    = 32'h5;
        b_in    = 32'h3;
        start2  = 1'b0;
        start32 = 1'b0;
        start8  = 1'b1;     // reset must win over start
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_zero(8, "reset");
        check_idle_zero(2, "reset");
        check_idle_zero(32, "reset");
        start8 = 1'b0;
        rst    = 1'b0;
        for (int w = 0; w <= 32; w++) last_sum[w] = '0;
    endtask

    task automatic test_directed();
        start_op(8, 32'h0F, 32'h01, 1'b0); track(8, 32'h10, 1'b0, 1'b0, 0, "add_0f_01");
        start_op(8, 32'h7F, 32'h01, 1'b0); track(8, 32'h80, 1'b0, 1'b1, 1, "add_7f_01");
        start_op(8, 32'hFF, 32'h01, 1'b0); track(8, 32'h00, 1'b1, 1'b0, 1, "add_ff_01");
        start_op(8, 32'h05, 32'h07, 1'b1); track(8, 32'hFE, 1'b0, 1'b0, 1, "sub_05_07");
        start_op(8, 32'h80, 32'h01, 1'b1); track(8, 32'h7F, 1'b1, 1'b1, 1, "sub_80_01");
    endtask

    task automatic test_random();
        res_t        r;
        logic [31:0] ra, rb;
        logic        rs;
        int          widths [3] = '{8, 2, 32};
        foreach (widths[j]) begin
            for (int n = 0; n < 8; n++) begin
                ra = $urandom;
                rb = $urandom;
                rs = 1'($urandom);
                r  = model(widths[j], ra, rb, rs);
                start_op(widths[j], ra, rb, rs);
                track(widths[j], r.sum, r.cout, r.ovf, 1, "random");
            end
        end
    endtask

    task automatic test_ignore_start();
        start_op(8, 32'h21, 32'h13, 1'b0);
        track(8, 32'h34, 1'b0, 1'b0, 2, "ignore_start");
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bit   pulsed;
        start_op(8, 32'h12, 32'h34, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);             // cycle 4 of the operation
        rst = 1'b1;
        @(negedge clk);
        check_idle_zero(8, "reset_mid");
        rst = 1'b0;
        for (int w = 0; w <= 32; w++) last_sum[w] = '0;
        pulsed = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            o = observe(8);
            if (o.done === 1'b1) pulsed = 1'b1;
        end
        checks++;
        if (pulsed) begin
            failures++;
            $display("FAIL reset_mid_done: got a done pulse after abort, want none");
        end
        start_op(8, 32'h02, 32'h03, 1'b0);
        track(8, 32'h05, 1'b0, 1'b0, 0, "after_reset");
    endtask

    task automatic test_back_to_back(input int w,
                                     input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                                     input logic [31:0] e1, input logic c1, input logic o1,
                                     input logic [31:0] a2, input logic [31:0] b2, input logic s2);
        res_t r;
        @(negedge clk);
        a_in   = a1;
        b_in   = b1;
        sub_in = s1;
        set_start(w, 1'b1);
        @(posedge clk);
        #1;
        // start stays high; these operands must be ignored until done.
        a_in   = a2;
        b_in   = b2;
        sub_in = s2;
        track(w, e1, c1, o1, 0, "b2b_first");
        @(posedge clk);
        #1;
        set_start(w, 1'b0);
        r = model(w, a2, b2, s2);
        track(w, r.sum, r.cout, r.ovf, 0, "b2b_second");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back(8,  32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0,
                          32'h40, 32'h55, 1'b1);
        test_back_to_back(2,  32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b1,
                          32'h0, 32'h1, 1'b1);
        test_back_to_back(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0,
                          32'h8000_0000, 32'h1, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
